data_sram_resp: RTL and testbench

- Responder side of the CPU data-SRAM interface. The execute stage drives en/wen/addr/wdata; this block answers with rdata one cycle later for the memory stage.
- Single-port synchronous word RAM with byte write enables and write-first read-back. After reset, a clear sequencer zeroes the array. Out-of-window accesses are flagged.
- Sits beside the CPU core in the SoC top and replaces the vendor BRAM for simulation and FPGA builds.

---
 rtl/data_sram_resp_pkg.sv | 12 +
 rtl/data_sram_resp_bytearray.sv | 43 ++++
 rtl/data_sram_resp.sv | 103 ++++++++++
 tb/tb_data_sram_resp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-SRAM responder: SoC-level defaults and FSM states.
package data_sram_resp_pkg;

  localparam int          DSRAM_AW_DEFAULT   = 10;
  localparam logic [31:0] DSRAM_BASE_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dsram_state_t;

endpackage

// File: rtl/data_sram_resp_bytearray.sv
// 2**AW x 32 word array with byte write enables and a registered write-first output.
// Kept self-contained so an FPGA build can replace it with a vendor block RAM.
module dsram_bytearray #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          rd_req,
  input  logic          rd_zero,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] merged;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Write-first: enabled lanes come from the new data, the rest from the stored word.
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_zero) begin
      rdata <= '0;
    end else if (rd_req) begin
      rdata <= merged;
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Responder for the CPU data-SRAM port: zero-fill after reset, window check,
// one-cycle read latency with write-first merge and out-of-window error flags.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          AW             = DSRAM_AW_DEFAULT,
  parameter logic [31:0] BASE_ADDR      = DSRAM_BASE_DEFAULT,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_err,
  output logic        init_busy,
  output logic        err_sticky
);

  dsram_state_t  state, state_nxt;
  logic [AW-1:0] init_cnt;
  logic [AW-1:0] req_idx;
  logic          hit;
  logic          miss_req;
  logic [3:0]    arr_be;
  logic [AW-1:0] arr_addr;
  logic [31:0]   arr_wdata;
  logic          arr_rd;
  logic          arr_zero;
  logic [1:0]    addr_lsb_unused;

  assign hit             = (data_sram_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign req_idx         = data_sram_addr[AW+1:2];
  assign addr_lsb_unused = data_sram_addr[1:0];
  assign init_busy       = (state == ST_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) init_cnt <= init_cnt + 1'b1;
    end
  end

  // The array port is owned by the clear sequencer until it finishes; CPU requests are dropped meanwhile.
  always_comb begin
    state_nxt = state;
    arr_be    = '0;
    arr_addr  = req_idx;
    arr_wdata = data_sram_wdata;
    arr_rd    = 1'b0;
    arr_zero  = 1'b0;
    miss_req  = 1'b0;
    case (state)
      ST_CLEAR: begin
        arr_be    = 4'hF;
        arr_addr  = init_cnt;
        arr_wdata = '0;
        if (init_cnt == {AW{1'b1}}) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (data_sram_en) begin
          if (hit) begin
            arr_be = data_sram_wen;
            arr_rd = 1'b1;
          end else begin
            arr_zero = 1'b1;
            miss_req = 1'b1;
          end
        end
      end
      default: state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_err <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      data_sram_err <= miss_req;
      if (miss_req) err_sticky <= 1'b1;
    end
  end

  dsram_bytearray #(
    .AW(AW)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .be     (arr_be),
    .addr   (arr_addr),
    .wdata  (arr_wdata),
    .rd_req (arr_rd),
    .rd_zero(arr_zero),
    .rdata  (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp (AW=4, window at 0x1000_0000):
// directed steps followed by random traffic scored against a word-array model.
module tb_data_sram_resp;

  localparam int          AW    = 4;
  localparam int          WORDS = 1 << AW;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_err;
  logic        init_busy;
  logic        err_sticky;

  int tests_run;
  int tests_failed;

  logic [31:0] model_mem [WORDS];
  logic [31:0] model_rdata;
  logic        model_err;
  logic        model_sticky;

  data_sram_resp #(
    .AW            (AW),
    .BASE_ADDR     (BASE),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .data_sram_err  (data_sram_err),
    .init_busy      (init_busy),
    .err_sticky     (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One READY-state request: drive, clock it, then advance the reference model.
  task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned offset;
    logic [31:0] word;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    if (!en) begin
      model_err = 1'b0;
    end else if (addr >= BASE && addr < BASE + 32'(4 * WORDS)) begin
      offset = (addr - BASE) / 4;
      word   = model_mem[offset];
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) word[8*b +: 8] = wdata[8*b +: 8];
      end
      model_mem[offset] = word;
      model_rdata       = word;
      model_err         = 1'b0;
    end else begin
      model_rdata  = 32'h0;
      model_err    = 1'b1;
      model_sticky = 1'b1;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_rdata"}, data_sram_rdata, model_rdata);
    checkOutput({tag, "_err"}, {31'b0, data_sram_err}, {31'b0, model_err});
    checkOutput({tag, "_sticky"}, {31'b0, err_sticky}, {31'b0, model_sticky});
  endtask

  initial begin
    int n;
    logic [31:0] ra;
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rdata", data_sram_rdata, 32'h0);
    checkOutput("rst_err", {31'b0, data_sram_err}, 32'h0);
    checkOutput("rst_sticky", {31'b0, err_sticky}, 32'h0);
    checkOutput("rst_busy", {31'b0, init_busy}, 32'h1);

    // Requests during CLEAR must be ignored; reset after 7 cycles restarts it.
    reset           = 1'b0;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = BASE;
    data_sram_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      checkOutput("clr_busy", {31'b0, init_busy}, 32'h1);
      checkOutput("clr_rdata", data_sram_rdata, 32'h0);
      checkOutput("clr_err", {31'b0, data_sram_err}, 32'h0);
    end
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'b0, init_busy}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    while (init_busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      checkOutput("clr2_rdata", data_sram_rdata, 32'h0);
    end
    checkOutput("clear_len", 32'(n), 32'd16);
    checkOutput("clr_sticky", {31'b0, err_sticky}, 32'h0);

    for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
    model_rdata  = 32'h0;
    model_err    = 1'b0;
    model_sticky = 1'b0;

    for (int i = 0; i < WORDS; i++) begin
      applyStimulus(1'b1, 4'h0, BASE + 32'(4 * i), 32'h1234_5678);
      checkOutput("init_zero", data_sram_rdata, 32'h0);
      checkAll("init_read");
    end

    applyStimulus(1'b1, 4'hF, BASE + 32'h8, 32'hDEAD_BEEF);
    checkOutput("store_full", data_sram_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("idle_hold", data_sram_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    checkOutput("load_full", data_sram_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 4'b0010, BASE + 32'h9, 32'h0000_5500);
    checkOutput("store_byte", data_sram_rdata, 32'hDEAD_55EF);
    applyStimulus(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    checkOutput("load_byte", data_sram_rdata, 32'hDEAD_55EF);
    checkOutput("pre_miss_sticky", {31'b0, err_sticky}, 32'h0);

    applyStimulus(1'b1, 4'hF, 32'h2000_0008, 32'hCAFE_F00D);
    checkOutput("miss_rdata", data_sram_rdata, 32'h0);
    checkOutput("miss_err", {31'b0, data_sram_err}, 32'h1);
    checkOutput("miss_sticky", {31'b0, err_sticky}, 32'h1);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("miss_pulse", {31'b0, data_sram_err}, 32'h0);
    checkOutput("miss_hold_sticky", {31'b0, err_sticky}, 32'h1);
    applyStimulus(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    checkOutput("miss_nochange", data_sram_rdata, 32'hDEAD_55EF);

    // Window edges: last word hits, one past the end and one before the base miss.
    applyStimulus(1'b1, 4'hF, BASE + 32'h3C, 32'hA5A5_0F0F);
    checkAll("last_word");
    applyStimulus(1'b1, 4'hF, BASE + 32'h40, 32'h1111_1111);
    checkAll("past_end");
    applyStimulus(1'b1, 4'hF, BASE - 32'h4, 32'h2222_2222);
    checkAll("below_base");
    applyStimulus(1'b1, 4'h0, BASE, 32'h0);
    checkAll("word0");
    applyStimulus(1'b1, 4'h0, BASE + 32'h3F, 32'h0);
    checkOutput("last_word_rd", data_sram_rdata, 32'hA5A5_0F0F);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) ra = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
      else                          ra = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
      applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom), ra, $urandom);
      checkAll("rand");
    end

    for (int i = 0; i < WORDS; i++) begin
      applyStimulus(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
      checkAll("final_read");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
